median_sort_pipe: RTL and testbench
===================================

Name: median_sort_pipe

Overview:
- Parametrised, pipelined successor to the fixed 10-input combinational median/sort network.
- Sorts N lanes of W-bit data ascending with an odd-even transposition network of N compare-exchange layers.
- Pipeline registers sit after every REG_EVERY layers, with valid/ready handshaking and full-pipeline backpressure.
- Exposes the fully sorted vector and the median lane; used in datapath filters that need a per-sample median at line rate.

Parameters:
- N, 10, number of lanes (>=2; odd or even).
- W, 32, lane data width in bits.
- REG_EVERY, 2, compare-exchange layers between pipeline registers (1..N).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts input this cycle.
- data_in  in  N*W  input lanes; lane i = data_in[i*W +: W].
- out_valid  out  1  sorted result valid.
- out_ready  in  1  downstream accepts result this cycle.
- sort_out  out  N*W  sorted lanes ascending; lane 0 = minimum, same packing as data_in.
- median_out  out  W  lane (N-1)/2 of sort_out (lower median when N is even).

Behaviour:
- Network:
  - Layer k (k=0..N-1) compares pairs (i,i+1) with i ≡ k mod 2, i+1 < N.
  - Each exchange puts min in lane i and max in lane i+1.
  - Compare is a<=b, so equal values are not swapped.
- SIGNED=1: lanes are compared as signed W-bit values; no other width extension; all outputs stay W bits per lane.
- Stage count S = ceil(N/REG_EVERY).
  - Stage s contains layers s*REG_EVERY .. min(N,(s+1)*REG_EVERY)-1, followed by a register (data + valid bit).
  - Latency = S cycles from an accepted input to out_valid with no stall (defaults: S=5).
- Output registers:
  - sort_out, median_out and out_valid are driven directly from the last stage register.
  - No combinational path from data_in to any output.
- Handshake:
  - adv = !out_valid || out_ready; in_ready = adv.
  - Input accepted iff in_valid && in_ready.
  - When adv=1, every stage register loads from its predecessor. Stage 0 loads valid=in_valid and data=data_in.
  - When adv=0, all stage registers hold.
  - Bubbles are not compressed; they propagate as valid=0 slots.
- Stall stability:
  - While out_valid && !out_ready, sort_out and median_out are stable and in_ready=0.
  - No result is dropped or duplicated.
- in_ready depends combinationally on out_ready; that path is allowed.
- Reset:
  - rst_n=0 at a clock edge clears every stage valid bit and data register to 0.
  - Outputs after reset: out_valid=0, sort_out=0, median_out=0, in_ready=1.
  - Reset mid-operation discards all in-flight vectors. No out_valid pulse occurs for anything accepted before reset.
  - Input presented during the reset cycle is not captured.
- Simultaneous events: when an output is consumed and an input is accepted in the same cycle, both take effect, keeping full throughput of one vector per cycle.
- Data lanes of invalid slots are don't-care internally. The output registers always reflect the last stage register contents.

Test Plan:
1. Reset (defaults): hold rst_n=0 for 3 cycles with in_valid=1 and random data -> out_valid=0, sort_out=0, median_out=0, in_ready=1 throughout; no out_valid for 10 cycles after release while in_valid=0.
2. Single vector: lanes 0..9 = 9,8,7,6,5,4,3,2,1,0, out_ready=1 -> out_valid=1 exactly 5 cycles later for 1 cycle; sort_out lanes = 0..9; median_out=4.
3. Throughput: 4 back-to-back vectors {reverse order, all 7, 3,1,4,1,5,9,2,6,5,3, random}, out_ready=1 -> 4 consecutive out_valid cycles in input order; 3rd vector gives 1,1,2,3,3,4,5,5,6,9 and median 3.
4. Backpressure: the stream from test 3 with out_ready=0 from the first out_valid for 6 cycles -> out_valid held, sort_out stable, in_ready=0; after release, all 4 results emerge in order, none lost or repeated.
5. Signedness with N=5, REG_EVERY=1: inputs 0xFFFFFFFF,1,0,2,0x80000000 -> SIGNED=0 gives 0,1,2,0x80000000,0xFFFFFFFF, median 2; SIGNED=1 gives 0x80000000,0xFFFFFFFF,0,1,2, median 0; latency 5.
6. Reset mid-flight: accept 2 vectors, assert rst_n=0 one cycle at cycle 2 -> no out_valid afterwards; a new vector accepted post-reset appears exactly 5 cycles later and is correct.

Source files
------------

// File: rtl/median_sort_pipe.sv
// Pipelined odd-even transposition sorter: N lanes of W bits, a register after
// every REG_EVERY compare-exchange layers, valid/ready with whole-pipe stall.

module median_sort_cx #(
    parameter int W      = 32,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);
    logic le;

    // a<=b keeps equal values in place
    if (SIGNED != 0) begin : g_sgn
        assign le = $signed(a_i) <= $signed(b_i);
    end else begin : g_uns
        assign le = a_i <= b_i;
    end

    assign lo_o = le ? a_i : b_i;
    assign hi_o = le ? b_i : a_i;
endmodule

module median_sort_pipe #(
    parameter int N         = 10,
    parameter int W         = 32,
    parameter int REG_EVERY = 2,
    parameter int SIGNED    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] data_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] sort_out,
    output logic [W-1:0]   median_out
);
    localparam int S   = (N + REG_EVERY - 1) / REG_EVERY;
    localparam int MED = (N - 1) / 2;

    typedef logic [N-1:0][W-1:0] lanes_t;

    logic   adv;
    lanes_t in_lanes;

    assign in_lanes = data_in;

    genvar k, i, s;

    // Layer k pairs lanes (i,i+1) with i of the same parity as k; the first
    // layer of each stage reads the previous stage register.
    for (k = 0; k < N; k++) begin : g_layer
        lanes_t lin;
        lanes_t lout;

        if (k == 0) begin : g_src_in
            assign lin = in_lanes;
        end else if ((k % REG_EVERY) == 0) begin : g_src_reg
            assign lin = g_stage[k/REG_EVERY-1].data_q;
        end else begin : g_src_comb
            assign lin = g_layer[k-1].lout;
        end

        for (i = 0; i < N; i++) begin : g_lane
            if (((i % 2) == (k % 2)) && (i + 1 < N)) begin : g_cx
                median_sort_cx #(
                    .W      (W),
                    .SIGNED (SIGNED)
                ) u_cx (
                    .a_i  (lin[i]),
                    .b_i  (lin[i+1]),
                    .lo_o (lout[i]),
                    .hi_o (lout[i+1])
                );
            end else if (!((i >= 1) && (((i - 1) % 2) == (k % 2)))) begin : g_pass
                assign lout[i] = lin[i];
            end
        end
    end

    for (s = 0; s < S; s++) begin : g_stage
        localparam int LAST = (((s + 1) * REG_EVERY < N) ? (s + 1) * REG_EVERY : N) - 1;

        lanes_t data_q;
        lanes_t data_d;
        logic   vld_q;
        logic   vld_d;

        assign data_d = g_layer[LAST].lout;

        if (s == 0) begin : g_vin
            assign vld_d = in_valid;
        end else begin : g_vprev
            assign vld_d = g_stage[s-1].vld_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (adv) begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end
    end

    // Whole pipe advances together; bubbles travel as invalid slots.
    assign adv        = !out_valid || out_ready;
    assign in_ready   = adv;
    assign out_valid  = g_stage[S-1].vld_q;
    assign sort_out   = g_stage[S-1].data_q;
    assign median_out = g_stage[S-1].data_q[MED];
endmodule

// File: tb/tb_median_sort_pipe.sv
// Scoreboard bench for median_sort_pipe: defaults DUT plus two N=5 instances
// (unsigned / signed) for the signedness case.

module tb_median_sort_pipe;
    localparam int N  = 10;
    localparam int W  = 32;
    localparam int LAT = 5;

    typedef logic [N*W-1:0] vec_t;
    typedef struct {
        vec_t         v;
        logic [W-1:0] med;
        int           cyc;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    vec_t         data_in, sort_out;
    logic [W-1:0] median_out;

    logic         v5, u_ir, u_ov, s_ir, s_ov;
    logic [5*W-1:0] d5, u_so, s_so;
    logic [W-1:0] u_med, s_med;

    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   lat_en = 0;
    bit   stalled = 0;
    vec_t held;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_sort_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .sort_out(sort_out), .median_out(median_out)
    );

    median_sort_pipe #(.N(5), .W(32), .REG_EVERY(1), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(u_ir),
        .data_in(d5), .out_valid(u_ov), .out_ready(1'b1),
        .sort_out(u_so), .median_out(u_med)
    );

    median_sort_pipe #(.N(5), .W(32), .REG_EVERY(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(s_ir),
        .data_in(d5), .out_valid(s_ov), .out_ready(1'b1),
        .sort_out(s_so), .median_out(s_med)
    );

    task automatic chk(input string tag, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Reference: plain insertion sort, unsigned.
    function automatic exp_t model(input vec_t v);
        logic [W-1:0] a[N];
        logic [W-1:0] t;
        exp_t r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < N; i++) begin
            t = a[i];
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > t) begin a[j] = a[j-1]; a[j-1] = t; end
            end
        end
        for (int i = 0; i < N; i++) r.v[i*W +: W] = a[i];
        r.med = a[(N-1)/2];
        r.cyc = 0;
        r.lat = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_hold", sort_out, held);
                chk("stall_vld", vec_t'(out_valid), vec_t'(1));
            end
            if (out_valid && !out_ready) chk("stall_rdy", vec_t'(in_ready), vec_t'(0));
            if (sb.size() == 0) begin
                chk("idle", vec_t'(out_valid), vec_t'(0));
            end else if (out_valid && out_ready) begin
                e = sb.pop_front();
                chk("sort", sort_out, e.v);
                chk("median", vec_t'(median_out), vec_t'(e.med));
                if (e.lat) chk("latency", vec_t'(cyc - e.cyc), vec_t'(LAT));
            end
            if (in_valid && in_ready) begin
                e = model(data_in);
                e.cyc = cyc;
                e.lat = lat_en;
                sb.push_back(e);
            end
            stalled = out_valid && !out_ready;
            held = sort_out;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v);
        in_valid = 1'b1;
        data_in  = v;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", vec_t'(in_ready), vec_t'(1));
        in_valid = 1'b0;
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    vec_t v_rev, v_7, v_pi, v_rnd;
    int   pi_l[N] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};

    initial begin
        for (int i = 0; i < N; i++) begin
            v_rev[i*W +: W] = W'(9 - i);
            v_7[i*W +: W]   = W'(7);
            v_pi[i*W +: W]  = W'(pi_l[i]);
        end
        v_rnd = rnd_vec();

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; data_in = rnd_vec();
        v5 = 1'b0; d5 = '0;

        // Reset with valid input present
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ov", vec_t'(out_valid), vec_t'(0));
            chk("rst_so", sort_out, vec_t'(0));
            chk("rst_med", vec_t'(median_out), vec_t'(0));
            chk("rst_ir", vec_t'(in_ready), vec_t'(1));
            data_in = rnd_vec();
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        idle(10);

        // Single vector
        lat_en = 1;
        send(v_rev);
        chk("t2_expect", model(v_rev).v[4*W +: W], vec_t'(4));
        idle(8);

        // Back-to-back throughput
        send(v_rev); send(v_7); send(v_pi); send(v_rnd);
        idle(8);

        // Backpressure
        lat_en = 0;
        fork
            begin
                send(v_rev); send(v_7); send(v_pi); send(v_rnd);
                send(rnd_vec()); send(rnd_vec());
            end
            begin
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk); #1;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(20);
        chk("drain4", vec_t'(sb.size()), vec_t'(0));

        // Signedness on N=5, one layer per stage
        d5 = {32'h80000000, 32'd2, 32'd0, 32'd1, 32'hFFFFFFFF};
        v5 = 1'b1;
        @(negedge clk);
        chk("t5_ir", vec_t'({u_ir, s_ir}), vec_t'(2'b11));
        @(posedge clk); #1;
        v5 = 1'b0;
        begin
            int l5;
            l5 = 0;
            for (int t = 0; t < 12; t++) begin
                @(negedge clk);
                l5++;
                if (u_ov) break;
            end
            chk("t5_lat", vec_t'(l5), vec_t'(5));
            chk("t5_sov", vec_t'(s_ov), vec_t'(1));
            chk("t5_uso", vec_t'(u_so), vec_t'({32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd1, 32'd0}));
            chk("t5_umed", vec_t'(u_med), vec_t'(2));
            chk("t5_sso", vec_t'(s_so), vec_t'({32'd2, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h80000000}));
            chk("t5_smed", vec_t'(s_med), vec_t'(0));
        end
        idle(3);

        // Reset mid-flight
        lat_en = 1;
        send(v_pi); send(v_7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(12);
        send(v_rnd);
        idle(8);
        chk("drain", vec_t'(sb.size()), vec_t'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
